// File: rtl/l1_pkg.sv
// Shared definitions for the L1 cache memory-side blocks.
// Holds the line/beat geometry and the line-to-burst adapter state encoding.
package l1_pkg;

    localparam int unsigned LINE_WIDTH       = 256;
    localparam int unsigned BEAT_WIDTH       = 64;
    localparam int unsigned BEATS            = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned BEAT_CNT_WIDTH   = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } line_burst_state_t;

endpackage

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: memory-side responder for the L1 cache pmem port.
// Turns each 256-bit line read/write into a 4-beat, 64-bit burst and answers
// the cache with a one-cycle line_resp once the last beat has completed.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   line_read       line read request from the cache
//   line_write      line write request from the cache (wins over line_read)
//   line_address    line byte address; low offset bits are dropped
//   line_wdata      line to be written
//   line_rdata      assembled read line, valid in the line_resp cycle
//   line_resp       one-cycle completion pulse
//   burst_address   32-byte-aligned burst address
//   burst_read      burst read request, high for the whole read burst
//   burst_write     burst write request, high for the whole write burst
//   burst_wdata     current write beat
//   burst_rdata     incoming read beat
//   burst_resp      one strobe per accepted/valid beat
module line_burst_adapter
    import l1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BEATS - 1);

    line_burst_state_t                     state;
    logic [BEAT_CNT_WIDTH-1:0]             beat_cnt;
    logic [BEAT_CNT_WIDTH-1:0]             beat_cnt_inc;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]      latched_wdata;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]      rdata_line;
    logic                                  unused_offset_bits;

    assign beat_cnt_inc       = beat_cnt + 1'b1;
    assign line_rdata         = rdata_line;
    // The byte offset within the line is irrelevant to a whole-line burst.
    assign unused_offset_bits = ^line_address[LINE_OFFSET_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            line_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
            burst_wdata   <= '0;
            latched_wdata <= '0;
            rdata_line    <= '0;
        end else begin
            line_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    // A write wins if the cache raises both requests at once.
                    if (line_write) begin
                        state         <= WRITE;
                        burst_write   <= 1'b1;
                        burst_address <= {line_address[31:LINE_OFFSET_BITS],
                                          {LINE_OFFSET_BITS{1'b0}}};
                        latched_wdata <= line_wdata;
                        burst_wdata   <= line_wdata[BEAT_WIDTH-1:0];
                    end else if (line_read) begin
                        state         <= READ;
                        burst_read    <= 1'b1;
                        burst_address <= {line_address[31:LINE_OFFSET_BITS],
                                          {LINE_OFFSET_BITS{1'b0}}};
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        rdata_line[beat_cnt] <= burst_rdata;
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= DONE;
                            burst_read <= 1'b0;
                            line_resp  <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt_inc;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state       <= DONE;
                            burst_write <= 1'b0;
                            line_resp   <= 1'b1;
                        end else begin
                            beat_cnt    <= beat_cnt_inc;
                            // Present the next beat in the cycle after the accept.
                            burst_wdata <= latched_wdata[beat_cnt_inc];
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: a directed vector table,
// hand-written reset/spurious-strobe sequences and randomized transactions.
module tb_line_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int total = 0;
    int bad   = 0;
    logic [255:0] model_rdata;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rbeats;     // beat k of a read is rbeats[64*k +: 64]
        logic [31:0]  resp_pat;   // bit c: burst_resp in the c-th cycle after accept
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;  // line_rdata expected in the line_resp cycle
    } vec_t;

    vec_t tbl[4];

    line_burst_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one cache transaction from IDLE and follows it to the IDLE cycle after resp.
    task automatic do_txn(input vec_t v);
        int nresp = 0;
        int c     = 1;
        bit is_wr = v.wr;
        line_read    = v.rd;
        line_write   = v.wr;
        line_address = v.addr;
        line_wdata   = v.wdata;
        step();
        // Upstream scribbles after accept must not matter.
        line_address = ~v.addr;
        line_wdata   = ~v.wdata;
        while (nresp < 4 && c < 32) begin
            check("burst_read", burst_read, !is_wr);
            check("burst_write", burst_write, is_wr);
            check("burst_address", burst_address, v.exp_addr);
            check("line_resp_early", line_resp, 1'b0);
            if (is_wr) check("burst_wdata", burst_wdata, v.wdata[64*nresp +: 64]);
            burst_resp  = v.resp_pat[c];
            burst_rdata = burst_resp ? v.rbeats[64*nresp +: 64] : {$urandom, $urandom};
            step();
            if (burst_resp) nresp++;
            burst_resp = 1'b0;
            c++;
        end
        check("beat_budget", 32'(nresp), 32'd4);
        check("line_resp", line_resp, 1'b1);
        check("burst_read_done", burst_read, 1'b0);
        check("burst_write_done", burst_write, 1'b0);
        check("line_rdata", line_rdata, v.exp_rdata);
        step();
        line_read  = 1'b0;
        line_write = 1'b0;
        check("line_resp_one_cycle", line_resp, 1'b0);
        model_rdata = v.exp_rdata;
    endtask

    initial begin
        vec_t v;
        rst          = 1'b1;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_address = '0;
        line_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        model_rdata  = '0;

        // Directed vectors
        tbl[0].rd = 1; tbl[0].wr = 0; tbl[0].addr = 32'h0000_1234; tbl[0].wdata = '0;
        tbl[0].rbeats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        tbl[0].resp_pat = 32'h0000_001E; tbl[0].exp_addr = 32'h0000_1220;
        tbl[0].exp_rdata = tbl[0].rbeats;

        tbl[1].rd = 0; tbl[1].wr = 1; tbl[1].addr = 32'h8000_0040;
        tbl[1].wdata = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
                        64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
        tbl[1].rbeats = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        tbl[1].resp_pat = 32'h0000_0264; tbl[1].exp_addr = 32'h8000_0040;
        tbl[1].exp_rdata = tbl[0].rbeats;

        tbl[2].rd = 1; tbl[2].wr = 1; tbl[2].addr = 32'h0000_00FF;
        tbl[2].wdata = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        tbl[2].rbeats = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        tbl[2].resp_pat = 32'h0000_001E; tbl[2].exp_addr = 32'h0000_00E0;
        tbl[2].exp_rdata = tbl[0].rbeats;

        tbl[3].rd = 1; tbl[3].wr = 0; tbl[3].addr = 32'hFFFF_FFFF; tbl[3].wdata = '0;
        tbl[3].rbeats = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        tbl[3].resp_pat = 32'h0000_01AA; tbl[3].exp_addr = 32'hFFFF_FFE0;
        tbl[3].exp_rdata = tbl[3].rbeats;

        step();
        step();
        check("rst_line_resp", line_resp, 1'b0);
        check("rst_burst_read", burst_read, 1'b0);
        check("rst_burst_write", burst_write, 1'b0);
        check("rst_burst_address", burst_address, 32'h0);
        check("rst_burst_wdata", burst_wdata, 64'h0);
        check("rst_line_rdata", line_rdata, 256'h0);
        rst = 1'b0;
        step();

        // Back-to-back: each entry starts in the IDLE cycle right after the previous DONE.
        for (int i = 0; i < 4; i++) do_txn(tbl[i]);

        // Reset after two read beats abandons the burst with no resp.
        line_read    = 1'b1;
        line_address = 32'h0000_4000;
        step();
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hEEEE_0000_0000_0000 | 64'(i);
            step();
        end
        burst_resp = 1'b0;
        rst        = 1'b1;
        step();
        rst       = 1'b0;
        line_read = 1'b0;
        check("midrst_burst_read", burst_read, 1'b0);
        check("midrst_line_resp", line_resp, 1'b0);
        step();
        check("midrst_idle_read", burst_read, 1'b0);
        check("midrst_idle_resp", line_resp, 1'b0);
        v.rd = 1; v.wr = 0; v.addr = 32'h0000_4010; v.wdata = '0;
        v.rbeats = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
        v.resp_pat = 32'h0000_001E; v.exp_addr = 32'h0000_4000; v.exp_rdata = v.rbeats;
        do_txn(v);

        // Spurious strobes in IDLE must not start or advance anything.
        for (int i = 0; i < 3; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            check("spur_burst_read", burst_read, 1'b0);
            check("spur_burst_write", burst_write, 1'b0);
            check("spur_line_resp", line_resp, 1'b0);
        end
        burst_resp = 1'b0;
        check("spur_line_rdata", line_rdata, model_rdata);
        v.addr = 32'h0000_5000; v.exp_addr = 32'h0000_5000;
        v.rbeats = {64'hB4, 64'hB3, 64'hB2, 64'hB1}; v.exp_rdata = v.rbeats;
        do_txn(v);

        // Randomized transactions against the line-level model.
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r    = $urandom_range(0, 3);
            v.rd = (r != 2);
            v.wr = (r >= 2);
            v.addr = $urandom;
            for (int i = 0; i < 8; i++) begin
                v.wdata[32*i +: 32]  = $urandom;
                v.rbeats[32*i +: 32] = $urandom;
            end
            v.resp_pat = $urandom & 32'hFFFF_FFFE;
            if ($countones(v.resp_pat) < 4) v.resp_pat = v.resp_pat | 32'h0000_001E;
            v.exp_addr  = v.addr & 32'hFFFF_FFE0;
            v.exp_rdata = v.wr ? model_rdata : v.rbeats;
            do_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
